// File: rtl/pie_demod_pkg.sv
`default_nettype none
// pie_demod_pkg: state encoding and default timing constants shared by the PIE receiver files.
// rev 1.0
package pie_demod_pkg;

  localparam int CNT_W_DEFAULT     = 10;
  localparam int DELIM_MIN_DEFAULT = 20;
  localparam int DELIM_MAX_DEFAULT = 40;
  localparam int TARI_MIN_DEFAULT  = 10;
  localparam int TARI_MAX_DEFAULT  = 50;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELIM = 3'd1,
    ST_TARI  = 3'd2,
    ST_RTCAL = 3'd3,
    ST_CAL3  = 3'd4,
    ST_DATA  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pie_demod_edge_sync.sv
`default_nettype none
// pie_demod_edge_sync: 2-flop synchroniser and rise/fall pulses for the envelope input.
// Optional PIE_GLITCH_FILTER_EN adds a 2-sample agreement filter (+2 clk). rev 1.0
module pie_demod_edge_sync
  import pie_demod_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic env_async,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_q1;
  logic sync_q2;
  logic level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= env_async;
      sync_q2 <= sync_q1;
    end
  end

`ifdef PIE_GLITCH_FILTER_EN
  logic sync_q3;
  logic filt_q;

  // A new level is only taken once two consecutive samples agree on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q3 <= 1'b0;
      filt_q  <= 1'b0;
    end else begin
      sync_q3 <= sync_q2;
      if (sync_q2 == sync_q3) filt_q <= sync_q2;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_q2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_d <= 1'b0;
    else        level_d <= level;
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

endmodule
`default_nettype wire

// File: rtl/pie_demod.sv
`default_nettype none
// pie_demod: tag-side PIE receiver (delimiter, Tari, RTcal, TRcal, data slicing, frame flags).
// Build option PIE_GLITCH_FILTER_EN enables the input glitch filter. rev 1.0
module pie_demod
  import pie_demod_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEFAULT,
  parameter int DELIM_MIN = DELIM_MIN_DEFAULT,
  parameter int DELIM_MAX = DELIM_MAX_DEFAULT,
  parameter int TARI_MIN  = TARI_MIN_DEFAULT,
  parameter int TARI_MAX  = TARI_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_env_dem,
  input  logic             i_clear_cu,
  output logic             o_bit_dem,
  output logic             o_bit_vld_dem,
  output logic             o_sof_dem,
  output logic             o_preamble_dem,
  output logic [CNT_W-1:0] o_rtcal_dem,
  output logic [CNT_W-1:0] o_trcal_dem,
  output logic             o_eof_dem,
  output logic             o_err_dem
);

  localparam int LW = CNT_W + 2;
  localparam logic [LW-1:0] DELIM_MIN_L = LW'(DELIM_MIN);
  localparam logic [LW-1:0] DELIM_MAX_L = LW'(DELIM_MAX);
  localparam logic [LW-1:0] TARI_MIN_L  = LW'(TARI_MIN);
  localparam logic [LW-1:0] TARI_MAX_L  = LW'(TARI_MAX);
  localparam logic [LW-1:0] CNT_MAX_L   = LW'({CNT_W{1'b1}});

  logic level, rise, fall;

  pie_demod_edge_sync u_edge_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .env_async (i_env_dem),
    .level     (level),
    .rise      (rise),
    .fall      (fall)
  );

  logic [CNT_W-1:0] cnt;
  logic             cnt_sat;

  assign cnt_sat = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (rise | fall) cnt <= '0;
    else if (!cnt_sat)    cnt <= cnt + 1'b1;
  end

  // cur_len is the length of the run that ends at this edge; a symbol is high run + low run.
  logic [LW-1:0] cur_len, hi_len, sym_len;
  logic          hi_sat, sym_bad, low_run;

  assign cur_len = LW'(cnt) + LW'(1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_len <= '0;
      hi_sat <= 1'b0;
    end else if (fall) begin
      hi_len <= cur_len;
      hi_sat <= cnt_sat;
    end
  end

  assign sym_len = hi_len + cur_len;
  assign sym_bad = hi_sat | cnt_sat | (sym_len > CNT_MAX_L);
  assign low_run = ~level & ~fall;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tari_q, tari_d, rtcal_q, rtcal_d;
  logic [CNT_W-1:0] rtcal_o_d, trcal_o_d;
  logic             bit_d, bit_vld_d, sof_d, pre_d, eof_d, err_d;
  logic [LW-1:0]    tari_ext, rtcal_ext, pivot, rt_lo, rt_hi;

  assign tari_ext  = LW'(tari_q);
  assign rtcal_ext = LW'(rtcal_q);
  assign pivot     = LW'(rtcal_q[CNT_W-1:1]);
  assign rt_lo     = tari_ext << 1;
  assign rt_hi     = rt_lo + tari_ext;

  always_comb begin
    state_d   = state_q;
    tari_d    = tari_q;
    rtcal_d   = rtcal_q;
    rtcal_o_d = o_rtcal_dem;
    trcal_o_d = o_trcal_dem;
    pre_d     = o_preamble_dem;
    bit_d     = 1'b0;
    bit_vld_d = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    err_d     = 1'b0;
    if (i_clear_cu) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (fall) state_d = ST_DELIM;
        ST_DELIM: begin
          if (rise) begin
            state_d = (!cnt_sat && cur_len >= DELIM_MIN_L && cur_len <= DELIM_MAX_L)
                      ? ST_TARI : ST_IDLE;
          end else if (low_run && cur_len > DELIM_MAX_L) begin
            state_d = ST_IDLE;
          end
        end
        ST_TARI: begin
          if (rise) begin
            if (!sym_bad && sym_len >= TARI_MIN_L && sym_len <= TARI_MAX_L) begin
              tari_d  = sym_len[CNT_W-1:0];
              state_d = ST_RTCAL;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end else if (low_run && cur_len > DELIM_MAX_L) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_RTCAL: begin
          if (rise) begin
            if (!sym_bad && sym_len >= rt_lo && sym_len <= rt_hi) begin
              rtcal_d = sym_len[CNT_W-1:0];
              state_d = ST_CAL3;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end else if (low_run && cur_len > DELIM_MAX_L) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_CAL3: begin
          if (rise) begin
            if (sym_bad || sym_len < TARI_MIN_L) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              sof_d     = 1'b1;
              rtcal_o_d = rtcal_q;
              state_d   = ST_DATA;
              if (sym_len > rtcal_ext) begin
                pre_d     = 1'b1;
                trcal_o_d = sym_len[CNT_W-1:0];
              end else begin
                pre_d     = 1'b0;
                bit_vld_d = 1'b1;
                bit_d     = (sym_len > pivot);
              end
            end
          end else if (low_run && cur_len >= DELIM_MIN_L) begin
            err_d   = 1'b1;
            state_d = ST_DELIM;
          end
        end
        ST_DATA: begin
          // Symbols shorter than the minimum Tari can only be glitches.
          if (rise) begin
            if (sym_bad || sym_len > rtcal_ext || sym_len < TARI_MIN_L) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              bit_vld_d = 1'b1;
              bit_d     = (sym_len > pivot);
            end
          end else if (low_run && cur_len >= DELIM_MIN_L) begin
            err_d   = 1'b1;
            state_d = ST_DELIM;
          end else if (level && cur_len > rtcal_ext) begin
            eof_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      tari_q         <= '0;
      rtcal_q        <= '0;
      o_bit_dem      <= 1'b0;
      o_bit_vld_dem  <= 1'b0;
      o_sof_dem      <= 1'b0;
      o_preamble_dem <= 1'b0;
      o_rtcal_dem    <= '0;
      o_trcal_dem    <= '0;
      o_eof_dem      <= 1'b0;
      o_err_dem      <= 1'b0;
    end else begin
      state_q        <= state_d;
      tari_q         <= tari_d;
      rtcal_q        <= rtcal_d;
      o_bit_dem      <= bit_d;
      o_bit_vld_dem  <= bit_vld_d;
      o_sof_dem      <= sof_d;
      o_preamble_dem <= pre_d;
      o_rtcal_dem    <= rtcal_o_d;
      o_trcal_dem    <= trcal_o_d;
      o_eof_dem      <= eof_d;
      o_err_dem      <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pie_demod.sv
`timescale 1ns/1ps
`default_nettype none
// tb_pie_demod: directed frames against pie_demod with hand-computed expectations.
module tb_pie_demod;

  localparam int CNT_W = 10;
`ifdef PIE_GLITCH_FILTER_EN
  localparam int LAT            = 5;
  localparam int GLITCH_ERR_EXP = 0;
  localparam int GLITCH_EOF_EXP = 1;
`else
  localparam int LAT            = 3;
  localparam int GLITCH_ERR_EXP = 1;
  localparam int GLITCH_EOF_EXP = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic env   = 1'b1;
  logic clear = 1'b0;

  logic             o_bit_dem, o_bit_vld_dem, o_sof_dem, o_preamble_dem, o_eof_dem, o_err_dem;
  logic [CNT_W-1:0] o_rtcal_dem, o_trcal_dem;

  pie_demod dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_env_dem      (env),
    .i_clear_cu     (clear),
    .o_bit_dem      (o_bit_dem),
    .o_bit_vld_dem  (o_bit_vld_dem),
    .o_sof_dem      (o_sof_dem),
    .o_preamble_dem (o_preamble_dem),
    .o_rtcal_dem    (o_rtcal_dem),
    .o_trcal_dem    (o_trcal_dem),
    .o_eof_dem      (o_eof_dem),
    .o_err_dem      (o_err_dem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_sof = 0, n_bit = 0, n_eof = 0, n_err = 0, n_sofbit = 0;
  int sof_lat = -1;
  int last_rise = 0;
  bit bits_q[$];
  int errors = 0, checks = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_sof_dem) begin
        n_sof++;
        sof_lat = cyc - last_rise;
        if (o_bit_vld_dem) n_sofbit++;
      end
      if (o_bit_vld_dem) begin
        n_bit++;
        bits_q.push_back(o_bit_dem);
      end
      if (o_eof_dem) n_eof++;
      if (o_err_dem) n_err++;
    end
  end

  function automatic int pack_bits(input int base);
    int v = 0;
    for (int i = base; i < bits_q.size(); i++) v = v * 2 + int'(bits_q[i]);
    return v;
  endfunction

  task automatic drive(input logic lvl, input int n);
    if (lvl && !env) last_rise = cyc;
    env = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Symbol of rise-to-rise length len: high, then a 6-cycle low pulse.
  task automatic sym(input int len);
    drive(1'b1, len - 6);
    drive(1'b0, 6);
  endtask

  task automatic send_frame(input bit with_tr, input int rt, input int b0, input int b1);
    drive(1'b0, 24);
    sym(20);
    sym(rt);
    if (with_tr) sym(100);
    sym(b0);
    sym(b1);
    drive(1'b1, 60);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({o_bit_dem, o_bit_vld_dem, o_sof_dem, o_preamble_dem, o_eof_dem, o_err_dem,
         o_rtcal_dem, o_trcal_dem} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero outputs rtcal=%0d trcal=%0d, expected all 0",
               o_rtcal_dem, o_trcal_dem);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 20);
    checks++;
    if (n_sof + n_bit + n_eof + n_err !== 0) begin
      errors++;
      $display("FAIL reset_idle_strobes: got %0d strobes, expected 0", n_sof + n_bit + n_eof + n_err);
    end
  endtask

  task automatic test_frame_trcal();
    int s0 = n_sof, b0 = n_bit, e0 = n_eof, r0 = n_err, q0 = bits_q.size();
    send_frame(1'b1, 50, 35, 20);
    checks++; if (n_sof - s0 !== 1) begin errors++; $display("FAIL t1_sof: got %0d expected 1", n_sof - s0); end
    checks++; if (sof_lat !== LAT) begin errors++; $display("FAIL t1_sof_latency: got %0d expected %0d", sof_lat, LAT); end
    checks++; if (o_preamble_dem !== 1'b1) begin errors++; $display("FAIL t1_preamble: got %0b expected 1", o_preamble_dem); end
    checks++; if (o_trcal_dem !== 10'd100) begin errors++; $display("FAIL t1_trcal: got %0d expected 100", o_trcal_dem); end
    checks++; if (o_rtcal_dem !== 10'd50) begin errors++; $display("FAIL t1_rtcal: got %0d expected 50", o_rtcal_dem); end
    checks++; if (n_bit - b0 !== 2) begin errors++; $display("FAIL t1_bit_count: got %0d expected 2", n_bit - b0); end
    checks++; if (pack_bits(q0) !== 2) begin errors++; $display("FAIL t1_bits: got %0d expected 2 (1,0)", pack_bits(q0)); end
    checks++; if (n_eof - e0 !== 1) begin errors++; $display("FAIL t1_eof: got %0d expected 1", n_eof - e0); end
    checks++; if (n_err - r0 !== 0) begin errors++; $display("FAIL t1_err: got %0d expected 0", n_err - r0); end
  endtask

  task automatic test_frame_no_trcal();
    int s0 = n_sof, b0 = n_bit, e0 = n_eof, q0 = bits_q.size(), sb0 = n_sofbit;
    send_frame(1'b0, 48, 35, 20);
    checks++; if (n_sof - s0 !== 1) begin errors++; $display("FAIL t2_sof: got %0d expected 1", n_sof - s0); end
    checks++; if (n_sofbit - sb0 !== 1) begin errors++; $display("FAIL t2_sof_with_bit: got %0d expected 1", n_sofbit - sb0); end
    checks++; if (o_preamble_dem !== 1'b0) begin errors++; $display("FAIL t2_preamble: got %0b expected 0", o_preamble_dem); end
    checks++; if (o_trcal_dem !== 10'd100) begin errors++; $display("FAIL t2_trcal_held: got %0d expected 100", o_trcal_dem); end
    checks++; if (o_rtcal_dem !== 10'd48) begin errors++; $display("FAIL t2_rtcal: got %0d expected 48", o_rtcal_dem); end
    checks++; if (n_bit - b0 !== 2 || pack_bits(q0) !== 2) begin errors++; $display("FAIL t2_bits: got n=%0d v=%0d expected n=2 v=2", n_bit - b0, pack_bits(q0)); end
    checks++; if (n_eof - e0 !== 1) begin errors++; $display("FAIL t2_eof: got %0d expected 1", n_eof - e0); end
  endtask

  task automatic test_bad_timing();
    int tot0 = n_sof + n_bit + n_eof + n_err;
    int s0, r0;
    drive(1'b0, 15);
    drive(1'b1, 40);
    checks++; if (n_sof + n_bit + n_eof + n_err - tot0 !== 0) begin errors++; $display("FAIL t3_delim15: got %0d strobes expected 0", n_sof + n_bit + n_eof + n_err - tot0); end
    tot0 = n_sof + n_bit + n_eof + n_err;
    drive(1'b0, 45);
    drive(1'b1, 40);
    checks++; if (n_sof + n_bit + n_eof + n_err - tot0 !== 0) begin errors++; $display("FAIL t3_delim45: got %0d strobes expected 0", n_sof + n_bit + n_eof + n_err - tot0); end
    s0 = n_sof; r0 = n_err;
    drive(1'b0, 24);
    sym(60);
    drive(1'b1, 40);
    checks++; if (n_err - r0 !== 1) begin errors++; $display("FAIL t3_tari60_err: got %0d expected 1", n_err - r0); end
    checks++; if (n_sof - s0 !== 0) begin errors++; $display("FAIL t3_tari60_sof: got %0d expected 0", n_sof - s0); end
    checks++; if (o_rtcal_dem !== 10'd48) begin errors++; $display("FAIL t3_rtcal_held: got %0d expected 48", o_rtcal_dem); end
  endtask

  task automatic test_redelim();
    int s0 = n_sof, b0 = n_bit, e0 = n_eof, r0 = n_err, q0 = bits_q.size();
    drive(1'b0, 24); sym(20); sym(50); sym(100); sym(35);
    drive(1'b1, 14);
    drive(1'b0, 24); sym(20); sym(50); sym(20); sym(35);
    drive(1'b1, 60);
    checks++; if (n_err - r0 !== 1) begin errors++; $display("FAIL t4_err: got %0d expected 1", n_err - r0); end
    checks++; if (n_sof - s0 !== 2) begin errors++; $display("FAIL t4_sof: got %0d expected 2", n_sof - s0); end
    checks++; if (n_bit - b0 !== 3 || pack_bits(q0) !== 5) begin errors++; $display("FAIL t4_bits: got n=%0d v=%0d expected n=3 v=5", n_bit - b0, pack_bits(q0)); end
    checks++; if (n_eof - e0 !== 1) begin errors++; $display("FAIL t4_eof: got %0d expected 1", n_eof - e0); end
    checks++; if (o_preamble_dem !== 1'b0) begin errors++; $display("FAIL t4_preamble: got %0b expected 0", o_preamble_dem); end
  endtask

  task automatic test_clear();
    int s0 = n_sof, b0 = n_bit, e0 = n_eof, r0 = n_err, q0;
    drive(1'b0, 24); sym(20); sym(50); sym(100);
    drive(1'b1, 29);
    drive(1'b0, 6);
    last_rise = cyc;
    env = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    drive(1'b1, 60);
    checks++; if (n_sof - s0 !== 1) begin errors++; $display("FAIL t5_sof: got %0d expected 1", n_sof - s0); end
    checks++; if (n_bit - b0 !== 0) begin errors++; $display("FAIL t5_no_bit: got %0d expected 0", n_bit - b0); end
    checks++; if (n_eof - e0 + n_err - r0 !== 0) begin errors++; $display("FAIL t5_no_eof_err: got %0d expected 0", n_eof - e0 + n_err - r0); end
    s0 = n_sof; b0 = n_bit; e0 = n_eof; q0 = bits_q.size();
    send_frame(1'b1, 50, 35, 20);
    checks++; if (n_sof - s0 !== 1) begin errors++; $display("FAIL t5_next_sof: got %0d expected 1", n_sof - s0); end
    checks++; if (n_bit - b0 !== 2 || pack_bits(q0) !== 2) begin errors++; $display("FAIL t5_next_bits: got n=%0d v=%0d expected n=2 v=2", n_bit - b0, pack_bits(q0)); end
    checks++; if (n_eof - e0 !== 1) begin errors++; $display("FAIL t5_next_eof: got %0d expected 1", n_eof - e0); end
  endtask

  task automatic test_glitch();
    int s0 = n_sof, b0 = n_bit, e0 = n_eof, r0 = n_err;
    drive(1'b0, 24); sym(20); sym(50); sym(100); sym(35);
    drive(1'b1, 5);
    drive(1'b0, 1);
    drive(1'b1, 66);
    checks++; if (n_sof - s0 !== 1) begin errors++; $display("FAIL t6_sof: got %0d expected 1", n_sof - s0); end
    checks++; if (n_bit - b0 !== 1) begin errors++; $display("FAIL t6_bits: got %0d expected 1", n_bit - b0); end
    checks++; if (n_err - r0 !== GLITCH_ERR_EXP) begin errors++; $display("FAIL t6_err: got %0d expected %0d", n_err - r0, GLITCH_ERR_EXP); end
    checks++; if (n_eof - e0 !== GLITCH_EOF_EXP) begin errors++; $display("FAIL t6_eof: got %0d expected %0d", n_eof - e0, GLITCH_EOF_EXP); end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_trcal();
    test_frame_no_trcal();
    test_bad_timing();
    test_redelim();
    test_clear();
    test_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
